// File: rtl/mgmt_sram_ro_pkg.sv
// Shared types and defaults for the management SRAM read-only burst reader.
package mgmt_sram_ro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    SHIFT = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_READ_LAT   = 1;

endpackage

// File: rtl/mgmt_sram_ro_reader_if.sv
// Request, SRAM read port and byte-stream signals of the burst reader.
interface mgmt_sram_ro_reader_if
  import mgmt_sram_ro_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W:0]   req_len;
  logic              abort;
  logic              sram_ro_csb;
  logic [ADDR_W-1:0] sram_ro_addr;
  logic [31:0]       sram_ro_data;
  logic              byte_valid;
  logic              byte_ready;
  logic [7:0]        byte_data;
  logic              busy;
  logic              done;

  modport slave (
    input  req_valid, req_addr, req_len, abort, sram_ro_data, byte_ready,
    output req_ready, sram_ro_csb, sram_ro_addr, byte_valid, byte_data, busy, done
  );

  modport master (
    output req_valid, req_addr, req_len, abort, sram_ro_data, byte_ready,
    input  req_ready, sram_ro_csb, sram_ro_addr, byte_valid, byte_data, busy, done
  );
endinterface

// File: rtl/sram_ro_word_serializer.sv
// Holds one 32-bit SRAM word and emits it MSB byte first over valid/ready.
module sram_ro_word_serializer
  import mgmt_sram_ro_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        flush,
  input  logic        byte_ready,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        word_done
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [31:0] data_p0;
  logic [1:0]  idx_p0;
  logic        vld_p0;

  // The current byte always sits in the top lane; accepted bytes shift out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p0 <= '0;
      idx_p0  <= '0;
      vld_p0  <= 1'b0;
    end else if (flush) begin
      idx_p0  <= '0;
      vld_p0  <= 1'b0;
    end else if (load) begin
      data_p0 <= word;
      idx_p0  <= '0;
      vld_p0  <= 1'b1;
    end else if (vld_p0 && byte_ready) begin
      data_p0 <= {data_p0[23:0], 8'h00};
      idx_p0  <= idx_p0 + 2'd1;
      if (idx_p0 == LAST_IDX) vld_p0 <= 1'b0;
    end
  end

  assign byte_valid = vld_p0;
  assign byte_data  = data_p0[31:24];
  assign word_done  = vld_p0 && byte_ready && (idx_p0 == LAST_IDX);

endmodule

// File: rtl/mgmt_sram_ro_reader.sv
// Burst reader: single-word reads on the SRAM read-only port, streamed out as bytes.
module mgmt_sram_ro_reader
  import mgmt_sram_ro_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int READ_LAT = DEF_READ_LAT  // 1..3
)(
  input  logic                  core_clk,
  input  logic                  core_rst,
  mgmt_sram_ro_reader_if.slave  bus
);

  localparam logic [1:0]      LAT_LAST = 2'(READ_LAT - 1);
  localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic [1:0]        lat_q;
  logic              done_q, done_d;
  logic              accept, load, flush, word_done, last_word;

  assign last_word = (rem_q == LEN_ONE);
  assign flush     = bus.abort && (state_q != IDLE);

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Abort is ignored in IDLE, so an abort coinciding with a request still accepts it.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (bus.req_len != '0) state_d = READ;
          else                   done_d  = 1'b1;
        end
      end
      READ: state_d = bus.abort ? IDLE : WAIT;
      WAIT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (lat_q == LAT_LAST) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (word_done) begin
          state_d = last_word ? IDLE : READ;
          done_d  = last_word;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address only moves on entry to READ so the port holds it between reads.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      addr_q <= '0;
      rem_q  <= '0;
      lat_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
      lat_q  <= (state_q == WAIT) ? lat_q + 2'd1 : 2'd0;
      if (state_d == READ && state_q != READ)
        addr_q <= (state_q == IDLE) ? bus.req_addr : addr_q + 1'b1;
      if (accept)
        rem_q <= bus.req_len;
      else if (state_q == SHIFT && !bus.abort && word_done)
        rem_q <= rem_q - LEN_ONE;
    end
  end

  sram_ro_word_serializer u_ser (
    .clk        (core_clk),
    .rst        (core_rst),
    .load       (load),
    .word       (bus.sram_ro_data),
    .flush      (flush),
    .byte_ready (bus.byte_ready),
    .byte_valid (bus.byte_valid),
    .byte_data  (bus.byte_data),
    .word_done  (word_done)
  );

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.sram_ro_csb  = (state_q != READ);
  assign bus.sram_ro_addr = addr_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_mgmt_sram_ro_reader.sv
// Directed self-checking bench for mgmt_sram_ro_reader with a 1-cycle SRAM model.
module tb_mgmt_sram_ro_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [256];
  logic [7:0]  byte_q[$];
  int          byte_cyc[$];
  int          csb_cyc[$];
  logic [7:0]  csb_addr[$];
  int          done_cnt = 0;

  mgmt_sram_ro_reader_if #(.ADDR_W(8)) bus ();

  mgmt_sram_ro_reader #(.ADDR_W(8), .READ_LAT(1)) dut (
    .core_clk (clk),
    .core_rst (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (!bus.sram_ro_csb) bus.sram_ro_data <= mem[bus.sram_ro_addr];

  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.sram_ro_csb) begin
        csb_cyc.push_back(cyc);
        csb_addr.push_back(bus.sram_ro_addr);
      end
      if (bus.byte_valid && bus.byte_ready) begin
        byte_q.push_back(bus.byte_data);
        byte_cyc.push_back(cyc);
      end
      if (bus.done) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mem_byte(int word_addr, int k);
    logic [31:0] w;
    w = mem[8'(word_addr)];
    return w[31-8*k -: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [7:0] addr, input logic [8:0] len);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = len;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b want 1", bus.req_ready); end
    checks++; if (bus.sram_ro_csb !== 1'b1) begin errors++; $display("FAIL reset_csb: got %0b want 1", bus.sram_ro_csb); end
    checks++; if (bus.sram_ro_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", bus.sram_ro_addr); end
    checks++; if (bus.byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid: got %0b want 0", bus.byte_valid); end
    checks++; if (bus.byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte_data: got %h want 00", bus.byte_data); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %0b%0b want 00", bus.busy, bus.done); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_word();
    logic [7:0] exp [4];
    exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    mem[8'h10] = 32'hA1B2C3D4;
    bus.byte_ready = 1'b1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL single_ready_T: got %0b want 1", bus.req_ready); end
    request(8'h10, 9'd1);
    checks++; if (bus.sram_ro_csb !== 1'b0 || bus.sram_ro_addr !== 8'h10) begin errors++; $display("FAIL single_read_T1: csb %0b addr %h want 0 10", bus.sram_ro_csb, bus.sram_ro_addr); end
    checks++; if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL single_busy_T1: busy %0b ready %0b want 1 0", bus.busy, bus.req_ready); end
    step();
    checks++; if (bus.sram_ro_csb !== 1'b1 || bus.byte_valid !== 1'b0) begin errors++; $display("FAIL single_wait_T2: csb %0b valid %0b want 1 0", bus.sram_ro_csb, bus.byte_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.byte_valid !== 1'b1 || bus.byte_data !== exp[i]) begin
        errors++; $display("FAIL single_byte%0d: valid %0b data %h want 1 %h", i, bus.byte_valid, bus.byte_data, exp[i]);
      end
    end
    step();
    checks++; if (bus.done !== 1'b1 || bus.req_ready !== 1'b1 || bus.byte_valid !== 1'b0) begin errors++; $display("FAIL single_done_T7: done %0b ready %0b valid %0b want 1 1 0", bus.done, bus.req_ready, bus.byte_valid); end
    step();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL single_done_T8: got %0b want 0", bus.done); end
  endtask

  task automatic test_wrap_max();
    int cb, bb, db, n;
    bit bad;
    cb = csb_cyc.size(); bb = byte_q.size(); db = done_cnt;
    bus.byte_ready = 1'b1;
    request(8'hFE, 9'd256);
    n = 0;
    while (bus.done !== 1'b1 && n < 2000) begin step(); n++; end
    checks++; if (n >= 2000) begin errors++; $display("FAIL wrap_timeout: no done after %0d cycles", n); end
    step(); step();
    checks++; if (csb_cyc.size() - cb != 256) begin errors++; $display("FAIL wrap_reads: got %0d want 256", csb_cyc.size() - cb); end
    checks++; if (byte_q.size() - bb != 1024) begin errors++; $display("FAIL wrap_bytes: got %0d want 1024", byte_q.size() - bb); end
    checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt - db); end
    if (csb_cyc.size() - cb == 256) begin
      bad = 1'b0;
      for (int i = 0; i < 256 && !bad; i++) begin
        checks++;
        if (csb_addr[cb+i] !== 8'(8'hFE + i)) begin
          bad = 1'b1; errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, csb_addr[cb+i], 8'(8'hFE + i));
        end
      end
      bad = 1'b0;
      for (int i = 1; i < 256 && !bad; i++) begin
        checks++;
        if (csb_cyc[cb+i] - csb_cyc[cb+i-1] != 6) begin
          bad = 1'b1; errors++; $display("FAIL wrap_period%0d: got %0d want 6", i, csb_cyc[cb+i] - csb_cyc[cb+i-1]);
        end
      end
    end
    if (byte_q.size() - bb == 1024) begin
      bad = 1'b0;
      for (int i = 0; i < 1024 && !bad; i++) begin
        checks++;
        if (byte_q[bb+i] !== mem_byte(8'hFE + i/4, i%4)) begin
          bad = 1'b1; errors++; $display("FAIL wrap_data%0d: got %h want %h", i, byte_q[bb+i], mem_byte(8'hFE + i/4, i%4));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int cb, bb, n, stalls;
    logic [15:0] lfsr;
    logic        prev_stall;
    logic [7:0]  prev_data;
    cb = csb_cyc.size(); bb = byte_q.size();
    lfsr = 16'hACE1; prev_stall = 1'b0; prev_data = 8'h00; stalls = 0;
    bus.byte_ready = 1'b0;
    request(8'h20, 9'd2);
    n = 0;
    while (bus.done !== 1'b1 && n < 300) begin
      if (prev_stall) begin
        checks++;
        if (bus.byte_valid !== 1'b1 || bus.byte_data !== prev_data) begin
          errors++; $display("FAIL bp_stable: valid %0b data %h want 1 %h", bus.byte_valid, bus.byte_data, prev_data);
        end
      end
      bus.byte_ready = lfsr[0];
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      prev_stall = bus.byte_valid && !bus.byte_ready;
      if (prev_stall) stalls++;
      prev_data  = bus.byte_data;
      step(); n++;
    end
    bus.byte_ready = 1'b1;
    checks++; if (n >= 300) begin errors++; $display("FAIL bp_timeout: no done after %0d cycles", n); end
    checks++; if (stalls == 0) begin errors++; $display("FAIL bp_no_stall: got %0d stalls want >0", stalls); end
    step();
    checks++; if (byte_q.size() - bb != 8 || csb_cyc.size() - cb != 2) begin errors++; $display("FAIL bp_counts: bytes %0d reads %0d want 8 2", byte_q.size() - bb, csb_cyc.size() - cb); end
    if (byte_q.size() - bb == 8 && csb_cyc.size() - cb == 2) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (byte_q[bb+i] !== mem_byte(8'h20 + i/4, i%4)) begin
          errors++; $display("FAIL bp_data%0d: got %h want %h", i, byte_q[bb+i], mem_byte(8'h20 + i/4, i%4));
        end
      end
      checks++; if (csb_cyc[cb+1] <= byte_cyc[bb+3]) begin errors++; $display("FAIL bp_second_read: read cyc %0d want > %0d", csb_cyc[cb+1], byte_cyc[bb+3]); end
      checks++; if (csb_addr[cb+1] !== 8'h21) begin errors++; $display("FAIL bp_addr1: got %h want 21", csb_addr[cb+1]); end
    end
  endtask

  task automatic test_abort();
    int db, bb, cb, seen, n;
    logic [7:0] exp_b;
    db = done_cnt; seen = 0; n = 0;
    bus.byte_ready = 1'b1;
    request(8'h30, 9'd4);
    while (n < 100) begin
      if (bus.byte_valid === 1'b1) begin
        if (seen == 5) break;
        seen++;
      end
      step(); n++;
    end
    checks++; if (n >= 100) begin errors++; $display("FAIL abort_reach: seen %0d bytes want 5", seen); end
    exp_b = mem_byte(8'h31, 1);
    checks++; if (bus.byte_data !== exp_b) begin errors++; $display("FAIL abort_byte: got %h want %h", bus.byte_data, exp_b); end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    checks++; if (bus.byte_valid !== 1'b0 || bus.sram_ro_csb !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_next: valid %0b csb %0b busy %0b want 0 1 0", bus.byte_valid, bus.sram_ro_csb, bus.busy); end
    checks++; if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort_done_ready: done %0b ready %0b want 0 1", bus.done, bus.req_ready); end
    step();
    checks++; if (done_cnt != db) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - db); end
    bb = byte_q.size(); cb = csb_cyc.size();
    request(8'h40, 9'd1);
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin step(); n++; end
    checks++; if (n >= 50) begin errors++; $display("FAIL abort_new_timeout: no done after %0d cycles", n); end
    step();
    checks++; if (byte_q.size() - bb != 4 || csb_cyc.size() - cb != 1) begin errors++; $display("FAIL abort_new_counts: bytes %0d reads %0d want 4 1", byte_q.size() - bb, csb_cyc.size() - cb); end
    if (byte_q.size() - bb == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (byte_q[bb+i] !== mem_byte(8'h40, i)) begin errors++; $display("FAIL abort_new_data%0d: got %h want %h", i, byte_q[bb+i], mem_byte(8'h40, i)); end
      end
    end
    checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL abort_new_done: got %0d want 1", done_cnt - db); end
  endtask

  task automatic test_zero_len();
    int cb, db;
    cb = csb_cyc.size(); db = done_cnt;
    request(8'h77, 9'd0);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.sram_ro_csb !== 1'b1) begin errors++; $display("FAIL zero_T1: done %0b busy %0b ready %0b csb %0b want 1 0 1 1", bus.done, bus.busy, bus.req_ready, bus.sram_ro_csb); end
    step();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_T2_done: got %0b want 0", bus.done); end
    step();
    checks++; if (csb_cyc.size() != cb || done_cnt - db != 1) begin errors++; $display("FAIL zero_activity: reads %0d dones %0d want 0 1", csb_cyc.size() - cb, done_cnt - db); end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    bus.byte_ready = 1'b1;
    request(8'h50, 9'd2);
    step();
    checks++; if (bus.busy !== 1'b1 || bus.sram_ro_addr !== 8'h50 || bus.sram_ro_csb !== 1'b1) begin errors++; $display("FAIL rstmid_wait: busy %0b addr %h csb %0b want 1 50 1", bus.busy, bus.sram_ro_addr, bus.sram_ro_csb); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1 || bus.sram_ro_csb !== 1'b1 || bus.sram_ro_addr !== 8'h00) begin errors++; $display("FAIL rstmid_ctl: ready %0b csb %0b addr %h want 1 1 00", bus.req_ready, bus.sram_ro_csb, bus.sram_ro_addr); end
    checks++; if (bus.byte_valid !== 1'b0 || bus.byte_data !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_out: valid %0b data %h busy %0b done %0b want 0 00 0 0", bus.byte_valid, bus.byte_data, bus.busy, bus.done); end
    step();
    rst = 1'b0;
    step();
    request(8'h10, 9'd1);
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin step(); n++; end
    checks++; if (n >= 50) begin errors++; $display("FAIL rstmid_recover: no done after %0d cycles", n); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = {8'(i), 8'(~i), 8'(i ^ 8'h5A), 8'(i + 8'h33)};
    bus.req_valid  = 1'b0;
    bus.req_addr   = 8'h00;
    bus.req_len    = 9'd0;
    bus.abort      = 1'b0;
    bus.byte_ready = 1'b0;
    test_reset();
    test_single_word();
    test_wrap_max();
    test_backpressure();
    test_abort();
    test_zero_len();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
